// File: rtl/alu16_seq.sv
// alu16_seq: sequences 16-bit adds/inc/dec through the 8-bit ALU as a low-byte pass, then a high-byte pass.
module alu16_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [3:0]  flags_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] result,
   output logic [3:0]  flags_out,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_fin,
   output logic [3:0]  alu_ctrl,
   input  logic [7:0]  alu_y,
   input  logic [3:0]  alu_fout
);
   typedef enum logic [1:0] {IDLE, LO, HI} state_t;
   localparam logic [1:0] OP_ADD16 = 2'b00, OP_ADDSP = 2'b01, OP_DEC = 2'b11;
   localparam logic [3:0] ADD = 4'b0000, ADC = 4'b0001, SUB = 4'b0010, SBC = 4'b0011;
   state_t      state, state_nxt;
   logic [1:0]  op_lat;
   logic [15:0] x_lat, y_lat;
   logic [3:0]  f_lat, flags_nxt;
   logic [7:0]  lo_byte;
   logic        lo_c, lo_h;
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         done      <= 1'b0;
         result    <= 16'h0000;
         flags_out <= 4'h0;
         op_lat    <= 2'b00;
         x_lat     <= 16'h0000;
         y_lat     <= 16'h0000;
         f_lat     <= 4'h0;
         lo_byte   <= 8'h00;
         lo_c      <= 1'b0;
         lo_h      <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= state == HI;
         if (state == IDLE && start) begin
            op_lat <= op;
            x_lat  <= x;
            y_lat  <= y;
            f_lat  <= flags_in;
         end
         if (state == LO) begin
            lo_byte <= alu_y;
            lo_c    <= alu_fout[0];
            lo_h    <= alu_fout[1];
         end
         if (state == HI) begin
            result    <= {alu_y, lo_byte};
            flags_out <= flags_nxt;
         end
      end
   end
   always_comb begin
      state_nxt = state == IDLE ? (start ? LO : IDLE) : state == LO ? HI : IDLE;
      alu_a     = state == LO ? x_lat[7:0] : state == HI ? x_lat[15:8] : 8'h00;
      alu_b     = state == LO ? (op_lat[1] ? 8'h01 : y_lat[7:0])
                : state == HI ? (op_lat == OP_ADD16 ? y_lat[15:8] : op_lat == OP_ADDSP ? {8{y_lat[7]}} : 8'h00)
                : 8'h00;
      alu_fin   = state == HI ? {3'b000, lo_c} : 4'h0;
      alu_ctrl  = state == LO ? (op_lat == OP_DEC ? SUB : ADD)
                : state == HI ? (op_lat == OP_DEC ? SBC : ADC)
                : 4'h0;
      // ADDSP flags come from the low-byte unsigned add, not the high pass
      flags_nxt = op_lat == OP_ADD16 ? {f_lat[3], 1'b0, alu_fout[1:0]}
                : op_lat == OP_ADDSP ? {2'b00, lo_h, lo_c}
                : f_lat;
      busy      = state != IDLE;
   end
endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: directed checks of alu16_seq against a behavioural 8-bit ALU model.
module tb_alu16_seq;
   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  op;
   logic [15:0] x, y;
   logic [3:0]  flags_in;
   logic        busy, done;
   logic [15:0] result;
   logic [3:0]  flags_out;
   logic [7:0]  alu_a, alu_b, alu_y;
   logic [3:0]  alu_fin, alu_ctrl, alu_fout;
   logic [8:0]  s9;
   logic [4:0]  s5;
   logic        cin;
   int          checks = 0, failures = 0;
   int          done_cnt;

   alu16_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .x(x), .y(y),
      .flags_in(flags_in), .busy(busy), .done(done), .result(result),
      .flags_out(flags_out), .alu_a(alu_a), .alu_b(alu_b), .alu_fin(alu_fin),
      .alu_ctrl(alu_ctrl), .alu_y(alu_y), .alu_fout(alu_fout)
   );

   always #5 clk = ~clk;

   always_comb begin
      cin = alu_ctrl[0] & alu_fin[0];
      s9 = alu_ctrl[1] ? {1'b0, alu_a} - {1'b0, alu_b} - {8'b0, cin}
                       : {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, cin};
      s5 = alu_ctrl[1] ? {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'b0, cin}
                       : {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'b0, cin};
      alu_y = s9[7:0];
      alu_fout = {s9[7:0] == 8'h00, alu_ctrl[1], s5[4], s9[8]};
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [15:0] xv, input logic [15:0] yv, input logic [3:0] fv);
      @(negedge clk);
      start = 1'b1; op = o; x = xv; y = yv; flags_in = fv;
      @(negedge clk);
      start = 1'b0; op = ~o; x = ~xv; y = ~yv; flags_in = ~fv;
   endtask

   task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] xv, input logic [15:0] yv,
                         input logic [3:0] fv, input logic [15:0] er, input logic [3:0] ef);
      issue(o, xv, yv, fv);
      check({tag, "_lo_busy"}, {15'b0, busy}, 16'd1);
      @(negedge clk);
      check({tag, "_hi_done"}, {15'b0, done}, 16'd0);
      @(negedge clk);
      check({tag, "_done"}, {15'b0, done}, 16'd1);
      check({tag, "_result"}, result, er);
      check({tag, "_flags"}, {12'b0, flags_out}, {12'b0, ef});
      @(negedge clk);
      check({tag, "_done_clr"}, {15'b0, done}, 16'd0);
      check({tag, "_hold"}, result, er);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 2'b00; x = 16'h0; y = 16'h0; flags_in = 4'h0;
      repeat (2) @(negedge clk);
      check("rst_result", result, 16'h0000);
      check("rst_flags", {12'b0, flags_out}, 16'h0000);
      check("rst_busy", {15'b0, busy}, 16'd0);
      check("rst_done", {15'b0, done}, 16'd0);
      check("rst_ctrl", {alu_a, alu_b}, 16'h0000);
      reset = 1'b0;
      run_op("add16_a", 2'b00, 16'h8A23, 16'h0605, 4'b1000, 16'h9028, 4'b1010);
      run_op("add16_b", 2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011);
      run_op("addsp_a", 2'b01, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0011);
      run_op("addsp_b", 2'b01, 16'h0000, 16'h00FF, 4'b1111, 16'hFFFF, 4'b0000);
      run_op("inc", 2'b10, 16'hFFFF, 16'h1234, 4'b1101, 16'h0000, 4'b1101);
      run_op("dec", 2'b11, 16'h0000, 16'h1234, 4'b0000, 16'hFFFF, 4'b0000);
      // start held for six cycles: two back-to-back completions, LO/HI starts ignored
      @(negedge clk);
      start = 1'b1; op = 2'b10; x = 16'h0010; y = 16'h0; flags_in = 4'h0;
      done_cnt = 0;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (i == 6) start = 1'b0;
         if (done) done_cnt++;
         if (i == 3 || i == 6) begin
            check($sformatf("held_done%0d", i), {15'b0, done}, 16'd1);
            check($sformatf("held_res%0d", i), result, 16'h0011);
         end else
            check($sformatf("held_busy%0d", i), {15'b0, busy}, i == 7 ? 16'd0 : 16'd1);
      end
      check("held_done_cnt", done_cnt[15:0], 16'd2);
      // reset during HI aborts with no done pulse
      issue(2'b11, 16'h0000, 16'h0, 4'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", {15'b0, busy}, 16'd0);
      check("abort_done", {15'b0, done}, 16'd0);
      check("abort_result", result, 16'h0000);
      reset = 1'b0;
      @(negedge clk);
      check("abort_no_done", {15'b0, done}, 16'd0);
      run_op("post_rst", 2'b00, 16'h1234, 16'h1111, 4'b0000, 16'h2345, 4'b0000);
      // reset and start together: reset wins
      @(negedge clk);
      reset = 1'b1; start = 1'b1;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check("rst_start_busy", {15'b0, busy}, 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
